// File: rtl/btn_conditioner.sv
// Two-channel push-button conditioner: synchronizer, debounce FSM and
// rising-edge pulse per channel, channels fully independent.

module btn_chan #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);

    typedef enum logic [1:0] {
        LO_STABLE,
        CHK_HI,
        HI_STABLE,
        CHK_LO
    } state_t;

    localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE_CYCLES - 1);

    logic   meta_q;
    logic   sync_q;
    state_t state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic   level_q, level_d;
    logic   rise_q, rise_d;

    // State, counter, synchronizer and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            state_q <= LO_STABLE;
            cnt_q   <= 8'd0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            meta_q  <= raw;
            sync_q  <= meta_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    // Next state and stability counter; a bounce discards the count
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            LO_STABLE: begin
                if (sync_q) begin
                    state_d = CHK_HI;
                    cnt_d   = 8'd0;
                end
            end
            CHK_HI: begin
                if (!sync_q) begin
                    state_d = LO_STABLE;
                    cnt_d   = 8'd0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = HI_STABLE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            HI_STABLE: begin
                if (!sync_q) begin
                    state_d = CHK_LO;
                    cnt_d   = 8'd0;
                end
            end
            CHK_LO: begin
                if (sync_q) begin
                    state_d = HI_STABLE;
                    cnt_d   = 8'd0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = LO_STABLE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = LO_STABLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // Outputs decoded from the next state so they land with the state flop
    always_comb begin
        level_d = (state_d == HI_STABLE) || (state_d == CHK_LO);
        rise_d  = (state_q == CHK_HI) && (state_d == HI_STABLE);
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

module btn_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_x_raw,
    input  logic btn_y_raw,
    output logic x,
    output logic y,
    output logic x_rise,
    output logic y_rise
);

    btn_chan #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan_x (
        .clk  (clk),
        .rst  (rst),
        .raw  (btn_x_raw),
        .level(x),
        .rise (x_rise)
    );

    btn_chan #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan_y (
        .clk  (clk),
        .rst  (rst),
        .raw  (btn_y_raw),
        .level(y),
        .rise (y_rise)
    );

endmodule

// File: doc/btn_conditioner.md
BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, meaning cycles a synchronized input must hold steady before its output changes; legal range 2..255.
REQ-002 The module SHALL have one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 btn_x_raw  input  1  unsynchronized, bouncing push-button for channel x.
REQ-006 btn_y_raw  input  1  unsynchronized, bouncing push-button for channel y.
REQ-007 x  output  1  debounced level of channel x; drives the downstream FSM input x.
REQ-008 y  output  1  debounced level of channel y; drives the downstream FSM input y.
REQ-009 x_rise  output  1  one-cycle pulse on the cycle x goes 0->1.
REQ-010 y_rise  output  1  one-cycle pulse on the cycle y goes 0->1.

Function
REQ-011 Each raw input SHALL pass through a 2-flop synchronizer; only the second flop (sync) is used by later logic.
REQ-012 Channels x and y SHALL be fully independent: separate synchronizer, 8-bit counter and FSM, with no shared state.
REQ-013 Per-channel FSM states: LO_STABLE, CHK_HI, HI_STABLE, CHK_LO.
REQ-014 LO_STABLE: output 0; when sync=1, go to CHK_HI with cnt=0; otherwise stay.
REQ-015 CHK_HI: output 0; when sync=0, return to LO_STABLE (bounce abort, cnt discarded).
REQ-016 CHK_HI: when sync=1 and cnt=DEBOUNCE_CYCLES-1, go to HI_STABLE; otherwise increment cnt.
REQ-017 HI_STABLE: output 1; when sync=0, go to CHK_LO with cnt=0; otherwise stay.
REQ-018 CHK_LO: output 1; when sync=1, return to HI_STABLE (bounce abort).
REQ-019 CHK_LO: when sync=0 and cnt=DEBOUNCE_CYCLES-1, go to LO_STABLE; otherwise increment cnt.
REQ-020 Outputs x and y SHALL be registered, decoded from state only, with no combinational path from raw inputs.
REQ-021 x_rise SHALL be high for exactly the one cycle after the CHK_HI->HI_STABLE transition of channel x; y_rise behaves the same for channel y.
REQ-022 No pulse output SHALL exist for falling transitions.
REQ-023 Latency: raw change held steady from before clock edge 1 -> output changes at edge DEBOUNCE_CYCLES+3 (19 with the default).
REQ-024 A raw glitch shorter than DEBOUNCE_CYCLES+1 cycles, after synchronization, SHALL NOT change the output.
REQ-025 cnt SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.
REQ-026 Simultaneous qualifying transitions on x and y SHALL produce x_rise and y_rise in the same cycle, so that {x,y} moves 00->11 in one cycle.

Reset
REQ-027 While rst=1: sync flops=0, cnt=0, FSMs=LO_STABLE, x=y=0, x_rise=y_rise=0, asynchronously.
REQ-028 Reset asserted mid-check SHALL abort the check; no rise pulse may follow reset release.
REQ-029 After reset release with a raw input already high, the full latency of REQ-023 SHALL apply before the output rises.

Verification
REQ-030 Hold btn_x_raw=1 from before edge 1, DEBOUNCE_CYCLES=16 -> x=1 at edge 19, x_rise high for one cycle, y stays 0.
REQ-031 Toggle btn_x_raw every 5 cycles for 100 cycles, then hold 1 -> x stays 0 during toggling and rises 19 edges after the final rising toggle.
REQ-032 With x=1, drop btn_x_raw to 0 for 10 cycles, then restore to 1 -> x stays 1, no x_rise.
REQ-033 Raise both raw inputs on the same cycle -> x, y, x_rise and y_rise all assert on the same edge ({x,y} 00->11).
REQ-034 Assert rst for 1 cycle at cnt=10 of a CHK_HI check, with raw still high -> all outputs 0 immediately; x rises 19 edges after rst release.
REQ-035 Set DEBOUNCE_CYCLES=2, hold btn_y_raw=1 -> y=1 at edge 5; a 2-cycle low glitch on btn_y_raw leaves y=1.
